// File: rtl/booth_pkg.sv
// -----------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the sequential radix-4 Booth multiplier:
//   - state_t      : controller states IDLE / RUN / DONE
//   - SDN_*        : bit positions of {single, double, negate} in the sdn word
//   - booth_encode : maps one overlapping multiplier triplet to its sdn word
// -----------------------------------------------------------------------------
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SDN_SINGLE = 2;
    localparam int SDN_DOUBLE = 1;
    localparam int SDN_NEG    = 0;

    // Triplet t = {x[2i+1], x[2i], x[2i-1]}.
    // Triplet 3'b111 encodes as negate-only; the partial-product generator
    // turns that into -0 = 0, so it contributes nothing.
    function automatic logic [2:0] booth_encode(input logic [2:0] t);
        logic [2:0] s;
        s             = 3'b000;
        s[SDN_SINGLE] = t[0] ^ t[1];
        s[SDN_DOUBLE] = (t[2] & ~t[1] & ~t[0]) | (~t[2] & t[1] & t[0]);
        s[SDN_NEG]    = t[2];
        return s;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// -----------------------------------------------------------------------------
// booth_pp_gen
// Combinational radix-4 Booth partial-product generator.
//   i_sdn [2:0]         : {single, double, negate} selection
//   i_y   [WIDTH-1:0]   : signed multiplicand
//   o_pp  [2*WIDTH-1:0] : sign-extended, optionally doubled/negated y
// -----------------------------------------------------------------------------
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]         i_sdn,
    input  logic [WIDTH-1:0]   i_y,
    output logic [2*WIDTH-1:0] o_pp
);

    logic [2*WIDTH-1:0] w_y_ext;
    logic [2*WIDTH-1:0] w_mag;

    // Select magnitude; sign-extend before doubling so y = -2^(WIDTH-1) doubles exactly
    always_comb begin
        w_y_ext = {{WIDTH{i_y[WIDTH-1]}}, i_y};
        w_mag   = {(2*WIDTH){1'b0}};
        if (i_sdn[SDN_SINGLE]) begin
            w_mag = w_y_ext;
        end else if (i_sdn[SDN_DOUBLE]) begin
            w_mag = w_y_ext << 1;
        end else begin
            w_mag = {(2*WIDTH){1'b0}};
        end
    end

    // Apply negation in 2*WIDTH two's complement
    always_comb begin
        o_pp = w_mag;
        if (i_sdn[SDN_NEG]) begin
            o_pp = {(2*WIDTH){1'b0}} - w_mag;
        end else begin
            o_pp = w_mag;
        end
    end

endmodule

// File: rtl/booth_seq_mult.sv
// -----------------------------------------------------------------------------
// booth_seq_mult
// Sequential radix-4 Booth multiplier: one triplet of x per clock, a single
// shared partial-product generator, 2*WIDTH signed accumulator.
//   clk, rst_n            : clock, asynchronous active-low reset
//   clr                   : synchronous abort back to IDLE
//   in_valid/in_ready,x,y : operand handshake (in_ready high only in IDLE)
//   out_valid/out_ready   : product handshake (out_valid high only in DONE)
//   product [2*WIDTH-1:0] : signed x*y, stable while in DONE
//   busy                  : high in RUN or DONE
//   sdn [2:0]             : {single,double,negate} of triplet used this RUN cycle
// -----------------------------------------------------------------------------
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic [2:0]           sdn
);

    localparam int            N    = WIDTH / 2;
    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_x;
    logic [WIDTH-1:0]     r_y;
    logic [CW-1:0]        r_i;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2:0]           r_sdn;

    logic                 w_accept;
    logic                 w_last;
    logic [CW-1:0]        w_i_next;
    logic [WIDTH:0]       w_x_ext;
    logic [2:0]           w_sdn_next;
    logic [2*WIDTH-1:0]   w_pp;
    logic [2*WIDTH-1:0]   w_pp_shift;

    assign w_accept = (r_state == IDLE) && in_valid && !clr;
    assign w_last   = (r_i == LAST);
    assign w_i_next = r_i + CW'(1);
    // x[-1] = 0 is appended below the LSB so triplet i starts at bit 2i
    assign w_x_ext  = {r_x, 1'b0};

    // Encode the triplet for the following iteration so sdn is a register
    always_comb begin
        w_sdn_next = booth_encode(w_x_ext[{w_i_next, 1'b0} +: 3]);
    end

    booth_pp_gen #(
        .WIDTH (WIDTH)
    ) u_pp_gen (
        .i_sdn (r_sdn),
        .i_y   (r_y),
        .o_pp  (w_pp)
    );

    assign w_pp_shift = w_pp << {r_i, 1'b0};

    // Controller state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; clr has priority over every transition
    always_comb begin
        w_state_next = r_state;
        if (clr) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_next = in_valid  ? RUN  : IDLE;
                RUN:     w_state_next = w_last    ? DONE : RUN;
                DONE:    w_state_next = out_ready ? IDLE : DONE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Operand capture, iteration counter, sdn register and accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x   <= {WIDTH{1'b0}};
            r_y   <= {WIDTH{1'b0}};
            r_i   <= {CW{1'b0}};
            r_acc <= {(2*WIDTH){1'b0}};
            r_sdn <= 3'b000;
        end else if (clr) begin
            r_i   <= {CW{1'b0}};
            r_acc <= {(2*WIDTH){1'b0}};
            r_sdn <= 3'b000;
        end else if (w_accept) begin
            r_x   <= x;
            r_y   <= y;
            r_i   <= {CW{1'b0}};
            r_acc <= {(2*WIDTH){1'b0}};
            r_sdn <= booth_encode({x[1], x[0], 1'b0});
        end else if (r_state == RUN) begin
            // Carry out of the MSB is dropped by the 2*WIDTH-bit add
            r_acc <= r_acc + w_pp_shift;
            r_i   <= w_last ? {CW{1'b0}} : w_i_next;
            r_sdn <= w_last ? 3'b000 : w_sdn_next;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign product   = r_acc;
    assign sdn       = r_sdn;

endmodule
